gate_bist: RTL



---
 rtl/gate_bist.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gate_bist.sv
// gate_bist: exhaustive built-in self test for the five-input gate network
// y = ((a & b) ^ (c | d)) | e.
//
// On a start request the block walks all 32 input vectors. It holds each one
// on the stimulus outputs for SETTLE_CYC cycles, then compares the returned y
// against an internal reference in a single CHECK cycle. It reports pass/fail,
// a saturating mismatch count and the first failing vector.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_start          level-sampled start request, honoured only in IDLE
//   i_y              output of the gate network under test
//   o_a..o_e         registered stimulus, {a,b,c,d,e} = vec[4:0]
//   o_busy           high from the first SETTLE through the last CHECK
//   o_done           one-cycle completion pulse
//   o_pass           last completed run had zero mismatches
//   o_err_cnt        mismatch count of the current or last run (saturating)
//   o_first_err_vld  at least one mismatch captured
//   o_first_err_vec  vector of the first mismatch
module gate_bist #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned ERR_W      = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_y,
    output logic             o_a,
    output logic             o_b,
    output logic             o_c,
    output logic             o_d,
    output logic             o_e,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic             o_first_err_vld,
    output logic [4:0]       o_first_err_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;
    localparam logic [ERR_W-1:0] ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [4:0]       vec_q, vec_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             pass_q, pass_d;
    logic             first_vld_q, first_vld_d;
    logic [4:0]       first_vec_q, first_vec_d;
    logic             expected_y;

    // Reference model of the gate network for the vector currently applied.
    assign expected_y = ((vec_q[4] & vec_q[3]) ^ (vec_q[2] | vec_q[1])) | vec_q[0];

    // Next-state and result-update logic. The stimulus register only moves
    // on entry into SETTLE (and back to 0 on leaving DONE). A pipelined
    // network therefore has the whole settle window to catch up.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        err_cnt_d   = err_cnt_q;
        pass_d      = pass_q;
        first_vld_d = first_vld_q;
        first_vec_d = first_vec_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d     = SETTLE;
                    vec_d       = 5'd0;
                    cnt_d       = 4'd0;
                    err_cnt_d   = '0;
                    pass_d      = 1'b0;
                    first_vld_d = 1'b0;
                    first_vec_d = 5'd0;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (i_y != expected_y) begin
                    // Saturate instead of wrapping so a large count never
                    // reads back as a small one.
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + ERR_ONE;
                    end
                    if (!first_vld_q) begin
                        first_vld_d = 1'b1;
                        first_vec_d = vec_q;
                    end
                end
                if (vec_q == 5'd31) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 5'd1;
                    cnt_d   = 4'd0;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                // err_cnt_q already includes the final CHECK's update.
                pass_d  = (err_cnt_q == '0);
                vec_d   = 5'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            vec_q       <= 5'd0;
            cnt_q       <= 4'd0;
            err_cnt_q   <= '0;
            pass_q      <= 1'b0;
            first_vld_q <= 1'b0;
            first_vec_q <= 5'd0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            err_cnt_q   <= err_cnt_d;
            pass_q      <= pass_d;
            first_vld_q <= first_vld_d;
            first_vec_q <= first_vec_d;
        end
    end

    assign {o_a, o_b, o_c, o_d, o_e} = vec_q;
    assign o_busy          = (state_q == SETTLE) || (state_q == CHECK);
    assign o_done          = (state_q == DONE);
    assign o_pass          = pass_q;
    assign o_err_cnt       = err_cnt_q;
    assign o_first_err_vld = first_vld_q;
    assign o_first_err_vec = first_vec_q;

endmodule
